// File: rtl/viterbi_pkg.sv
// Shared Viterbi definitions: packet geometry defaults, packet-width helper,
// symbol slicing helper (also used by the branch-metric unit) and FIFO flag bundle.
package viterbi_pkg;

    localparam int SYM_W_DEF     = 2;
    localparam int NUM_PAIRS_DEF = 8;
    localparam int SYM_MAX_W     = 8;
    localparam int PKT_MAX_W     = 256;

    typedef struct packed {
        logic full;
        logic empty;
        logic overflow;
    } fifo_flags_t;

    function automatic int pkt_w(input int sym_w, input int num_pairs);
        return sym_w * num_pairs;
    endfunction

    // Symbol k of a packet, right-aligned and masked to sym_w bits.
    function automatic logic [SYM_MAX_W-1:0] sym_sel(input logic [PKT_MAX_W-1:0] pkt,
                                                     input int k, input int sym_w);
        logic [PKT_MAX_W-1:0] sh;
        logic [SYM_MAX_W-1:0] mask;
        sh   = pkt >> (k * sym_w);
        mask = SYM_MAX_W'((1 << sym_w) - 1);
        return sh[SYM_MAX_W-1:0] & mask;
    endfunction

endpackage

// File: rtl/viterbi_fifo_mem.sv
// Packet storage for the Viterbi input FIFO: DEPTH x PKT_W registers,
// synchronous write, asynchronous read. Contents are not reset.
module viterbi_fifo_mem #(
    parameter  int DEPTH = 4,
    parameter  int PKT_W = 16,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we_i,
    input  logic [PTR_W-1:0] waddr_i,
    input  logic [PKT_W-1:0] wdata_i,
    input  logic [PTR_W-1:0] raddr_i,
    output logic [PKT_W-1:0] rdata_o
);

    logic [PKT_W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/viterbi_input_fifo.sv
// First-word-fall-through packet FIFO feeding the Viterbi decoder core, with flush,
// overflow reporting and optional duplicate filtering (macro VITERBI_IBUF_DUP_FILTER_EN).
module viterbi_input_fifo
    import viterbi_pkg::*;
#(
    parameter  int SYM_W     = SYM_W_DEF,
    parameter  int NUM_PAIRS = NUM_PAIRS_DEF,
    parameter  int DEPTH     = 4,
    parameter  int CNT_W     = 8,
    localparam int PKT_W     = pkt_w(SYM_W, NUM_PAIRS),
    localparam int LVL_W     = $clog2(DEPTH + 1),
    localparam int PTR_W     = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [PKT_W-1:0] in_data,
    input  logic             renew,
    output logic             out_valid,
    output logic [PKT_W-1:0] out_data,
    output logic [LVL_W-1:0] level,
    output logic             full,
    output logic             empty,
    output logic             overflow,
    output logic [CNT_W-1:0] drop_cnt,
    output logic             dup_drop
);

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0] level_q, level_d;
    logic             overflow_q, overflow_d;
    logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;
    logic             dup_drop_q, dup_drop_d;

    fifo_flags_t      flags;
    logic             push, pop, store, refuse, is_dup;
    logic [PKT_W-1:0] head;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign flags.full     = (level_q == LVL_W'(DEPTH));
    assign flags.empty    = (level_q == '0);
    assign flags.overflow = overflow_q;

    // Same-cycle renew frees the head slot, so a full FIFO may still accept.
    assign in_ready  = rst & (~flags.full | renew);
    assign out_valid = ~flags.empty;

    assign push   = in_valid & in_ready;
    assign pop    = renew & out_valid;
    assign refuse = in_valid & ~in_ready;
    assign store  = push & ~is_dup;

`ifdef VITERBI_IBUF_DUP_FILTER_EN
    logic [PKT_W-1:0] last_pkt_q;
    logic             last_vld_q;

    assign is_dup = last_vld_q & (in_data == last_pkt_q);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_vld_q <= 1'b0;
        end else if (flush) begin
            last_vld_q <= 1'b0;
        end else if (store) begin
            last_vld_q <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!flush && store) begin
            last_pkt_q <= in_data;
        end
    end
`else
    assign is_dup = 1'b0;
`endif

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        level_d    = level_q;
        overflow_d = overflow_q;
        drop_cnt_d = drop_cnt_q;
        dup_drop_d = 1'b0;
        if (flush) begin
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            level_d    = '0;
            overflow_d = 1'b0;
            drop_cnt_d = '0;
        end else begin
            if (store) begin
                wr_ptr_d = ptr_inc(wr_ptr_q);
            end
            if (pop) begin
                rd_ptr_d = ptr_inc(rd_ptr_q);
            end
            case ({store, pop})
                2'b10:   level_d = level_q + LVL_W'(1);
                2'b01:   level_d = level_q - LVL_W'(1);
                default: level_d = level_q;
            endcase
            if (refuse) begin
                overflow_d = 1'b1;
                if (drop_cnt_q != '1) begin
                    drop_cnt_d = drop_cnt_q + CNT_W'(1);
                end
            end
            dup_drop_d = push & is_dup;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            overflow_q <= 1'b0;
            drop_cnt_q <= '0;
            dup_drop_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            overflow_q <= overflow_d;
            drop_cnt_q <= drop_cnt_d;
            dup_drop_q <= dup_drop_d;
        end
    end

    viterbi_fifo_mem #(
        .DEPTH (DEPTH),
        .PKT_W (PKT_W)
    ) u_mem (
        .clk     (clk),
        .we_i    (store & ~flush),
        .waddr_i (wr_ptr_q),
        .wdata_i (in_data),
        .raddr_i (rd_ptr_q),
        .rdata_o (head)
    );

    // Zero the output bus whenever nothing is held so stale slots never leak.
    assign out_data = out_valid ? head : '0;
    assign level    = level_q;
    assign full     = flags.full;
    assign empty    = flags.empty;
    assign overflow = flags.overflow;
    assign drop_cnt = drop_cnt_q;
    assign dup_drop = dup_drop_q;

endmodule

// File: tb/tb_viterbi_input_fifo.sv
// Directed self-checking bench for viterbi_input_fifo (DEPTH=4, 16-bit packets).
module tb_viterbi_input_fifo;

    localparam int PKT_W = 16;

    logic              clk = 1'b0;
    logic              rst;
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic [PKT_W-1:0]  in_data;
    logic              renew;
    logic              out_valid;
    logic [PKT_W-1:0]  out_data;
    logic [2:0]        level;
    logic              full;
    logic              empty;
    logic              overflow;
    logic [7:0]        drop_cnt;
    logic              dup_drop;

    int errors = 0;
    int checks = 0;

    viterbi_input_fifo #(
        .SYM_W     (2),
        .NUM_PAIRS (8),
        .DEPTH     (4),
        .CNT_W     (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .renew     (renew),
        .out_valid (out_valid),
        .out_data  (out_data),
        .level     (level),
        .full      (full),
        .empty     (empty),
        .overflow  (overflow),
        .drop_cnt  (drop_cnt),
        .dup_drop  (dup_drop)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_pkt(input logic [PKT_W-1:0] d);
        in_valid = 1'b1;
        in_data  = d;
        step();
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = '0; renew = 1'b0;
        step(); step();
        checks++; if (level !== 3'd0)     begin errors++; $display("FAIL reset_level got=%0d exp=0", level); end
        checks++; if (empty !== 1'b1)     begin errors++; $display("FAIL reset_empty got=%b exp=1", empty); end
        checks++; if (full !== 1'b0)      begin errors++; $display("FAIL reset_full got=%b exp=0", full); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        checks++; if (out_data !== 16'h0) begin errors++; $display("FAIL reset_out_data got=%h exp=0000", out_data); end
        checks++; if (overflow !== 1'b0)  begin errors++; $display("FAIL reset_overflow got=%b exp=0", overflow); end
        checks++; if (drop_cnt !== 8'd0)  begin errors++; $display("FAIL reset_drop_cnt got=%0d exp=0", drop_cnt); end
        checks++; if (dup_drop !== 1'b0)  begin errors++; $display("FAIL reset_dup_drop got=%b exp=0", dup_drop); end
        checks++; if (in_ready !== 1'b0)  begin errors++; $display("FAIL reset_in_ready got=%b exp=0", in_ready); end
        rst = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b1)  begin errors++; $display("FAIL post_reset_in_ready got=%b exp=1", in_ready); end
    endtask

    task automatic test_single();
        push_pkt(16'hA5C3);
        checks++; if (out_valid !== 1'b1)    begin errors++; $display("FAIL single_out_valid got=%b exp=1", out_valid); end
        checks++; if (out_data !== 16'hA5C3) begin errors++; $display("FAIL single_out_data got=%h exp=a5c3", out_data); end
        checks++; if (level !== 3'd1)        begin errors++; $display("FAIL single_level got=%0d exp=1", level); end
        renew = 1'b1;
        step();
        renew = 1'b0;
        checks++; if (empty !== 1'b1)        begin errors++; $display("FAIL single_empty got=%b exp=1", empty); end
        checks++; if (out_data !== 16'h0)    begin errors++; $display("FAIL single_out_data_idle got=%h exp=0000", out_data); end
    endtask

    task automatic test_wrap();
        for (int i = 1; i <= 4; i++) push_pkt(PKT_W'(i));
        checks++; if (full !== 1'b1)     begin errors++; $display("FAIL wrap_full got=%b exp=1", full); end
        checks++; if (level !== 3'd4)    begin errors++; $display("FAIL wrap_level got=%0d exp=4", level); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL wrap_in_ready got=%b exp=0", in_ready); end
        for (int i = 1; i <= 4; i++) begin
            checks++;
            if (out_data !== PKT_W'(i)) begin errors++; $display("FAIL wrap_pop%0d got=%h exp=%h", i, out_data, PKT_W'(i)); end
            renew = 1'b1;
            step();
            renew = 1'b0;
        end
        checks++; if (empty !== 1'b1)    begin errors++; $display("FAIL wrap_empty got=%b exp=1", empty); end
    endtask

    task automatic test_overflow();
        for (int i = 1; i <= 4; i++) push_pkt(PKT_W'(i));
        in_valid = 1'b1;
        in_data  = 16'h0005;
        repeat (3) step();
        in_valid = 1'b0;
        checks++; if (overflow !== 1'b1)     begin errors++; $display("FAIL ovf_flag got=%b exp=1", overflow); end
        checks++; if (drop_cnt !== 8'd3)     begin errors++; $display("FAIL ovf_drop_cnt got=%0d exp=3", drop_cnt); end
        checks++; if (level !== 3'd4)        begin errors++; $display("FAIL ovf_level got=%0d exp=4", level); end
        checks++; if (out_data !== 16'h0001) begin errors++; $display("FAIL ovf_head got=%h exp=0001", out_data); end
    endtask

    task automatic test_full_push_pop();
        logic [PKT_W-1:0] exp_seq [4];
        exp_seq[0] = 16'h0002; exp_seq[1] = 16'h0003; exp_seq[2] = 16'h0004; exp_seq[3] = 16'h0006;
        in_valid = 1'b1;
        in_data  = 16'h0006;
        renew    = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b1)     begin errors++; $display("FAIL fpp_in_ready got=%b exp=1", in_ready); end
        step();
        in_valid = 1'b0;
        renew    = 1'b0;
        checks++; if (level !== 3'd4)        begin errors++; $display("FAIL fpp_level got=%0d exp=4", level); end
        checks++; if (drop_cnt !== 8'd3)     begin errors++; $display("FAIL fpp_drop_cnt got=%0d exp=3", drop_cnt); end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (out_data !== exp_seq[i]) begin errors++; $display("FAIL fpp_pop%0d got=%h exp=%h", i, out_data, exp_seq[i]); end
            renew = 1'b1;
            step();
            renew = 1'b0;
        end
        checks++; if (empty !== 1'b1)        begin errors++; $display("FAIL fpp_empty got=%b exp=1", empty); end
    endtask

    task automatic test_zero_and_flush();
        push_pkt(16'h0000);
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL zero_out_valid got=%b exp=1", out_valid); end
        checks++; if (out_data !== 16'h0) begin errors++; $display("FAIL zero_out_data got=%h exp=0000", out_data); end
        checks++; if (level !== 3'd1)     begin errors++; $display("FAIL zero_level got=%0d exp=1", level); end
        flush    = 1'b1;
        in_valid = 1'b1;
        in_data  = 16'h7777;
        step();
        flush    = 1'b0;
        in_valid = 1'b0;
        checks++; if (level !== 3'd0)     begin errors++; $display("FAIL flush_level got=%0d exp=0", level); end
        checks++; if (overflow !== 1'b0)  begin errors++; $display("FAIL flush_overflow got=%b exp=0", overflow); end
        checks++; if (drop_cnt !== 8'd0)  begin errors++; $display("FAIL flush_drop_cnt got=%0d exp=0", drop_cnt); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_out_valid got=%b exp=0", out_valid); end
        step();
        checks++; if (empty !== 1'b1)     begin errors++; $display("FAIL flush_stays_empty got=%b exp=1", empty); end
    endtask

    task automatic test_saturation();
        for (int i = 0; i < 4; i++) push_pkt(16'h0021 + PKT_W'(i));
        in_valid = 1'b1;
        in_data  = 16'h00FF;
        repeat (300) step();
        in_valid = 1'b0;
        checks++; if (drop_cnt !== 8'hFF)    begin errors++; $display("FAIL sat_drop_cnt got=%0d exp=255", drop_cnt); end
        checks++; if (out_data !== 16'h0021) begin errors++; $display("FAIL sat_head got=%h exp=0021", out_data); end
        flush = 1'b1;
        step();
        flush = 1'b0;
        checks++; if (drop_cnt !== 8'd0)     begin errors++; $display("FAIL sat_flush_cnt got=%0d exp=0", drop_cnt); end
    endtask

    task automatic test_dup_filter();
        int pulses = 0;
        logic [PKT_W-1:0] pkts [3];
`ifdef VITERBI_IBUF_DUP_FILTER_EN
        int exp_level = 2;
        int exp_pulses = 1;
        logic [PKT_W-1:0] exp_second = 16'h5678;
`else
        int exp_level = 3;
        int exp_pulses = 0;
        logic [PKT_W-1:0] exp_second = 16'h1234;
`endif
        pkts[0] = 16'h1234; pkts[1] = 16'h1234; pkts[2] = 16'h5678;
        for (int i = 0; i < 3; i++) begin
            push_pkt(pkts[i]);
            if (dup_drop === 1'b1) pulses++;
        end
        step();
        if (dup_drop === 1'b1) pulses++;
        checks++; if (level !== 3'(exp_level)) begin errors++; $display("FAIL dup_level got=%0d exp=%0d", level, exp_level); end
        checks++; if (pulses != exp_pulses)    begin errors++; $display("FAIL dup_pulses got=%0d exp=%0d", pulses, exp_pulses); end
        checks++; if (out_data !== 16'h1234)   begin errors++; $display("FAIL dup_head got=%h exp=1234", out_data); end
        renew = 1'b1;
        step();
        renew = 1'b0;
        checks++; if (out_data !== exp_second) begin errors++; $display("FAIL dup_second got=%h exp=%h", out_data, exp_second); end
        flush = 1'b1;
        step();
        flush = 1'b0;
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 4; i++) push_pkt(16'h0040 + PKT_W'(i));
        push_pkt(16'h0099);
        checks++; if (overflow !== 1'b1)  begin errors++; $display("FAIL ar_pre_overflow got=%b exp=1", overflow); end
        #2;
        rst = 1'b0;
        #1;
        checks++; if (level !== 3'd0)     begin errors++; $display("FAIL ar_level got=%0d exp=0", level); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL ar_out_valid got=%b exp=0", out_valid); end
        checks++; if (out_data !== 16'h0) begin errors++; $display("FAIL ar_out_data got=%h exp=0000", out_data); end
        checks++; if (full !== 1'b0)      begin errors++; $display("FAIL ar_full got=%b exp=0", full); end
        checks++; if (empty !== 1'b1)     begin errors++; $display("FAIL ar_empty got=%b exp=1", empty); end
        checks++; if (overflow !== 1'b0)  begin errors++; $display("FAIL ar_overflow got=%b exp=0", overflow); end
        checks++; if (drop_cnt !== 8'd0)  begin errors++; $display("FAIL ar_drop_cnt got=%0d exp=0", drop_cnt); end
        checks++; if (in_ready !== 1'b0)  begin errors++; $display("FAIL ar_in_ready got=%b exp=0", in_ready); end
        step();
        rst = 1'b1;
        push_pkt(16'hBEEF);
        checks++; if (out_data !== 16'hBEEF) begin errors++; $display("FAIL ar_recover got=%h exp=beef", out_data); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_wrap();
        test_overflow();
        test_full_push_pop();
        test_zero_and_flush();
        test_saturation();
        test_dup_filter();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
